// File: rtl/alu_exc_pkg.sv
// ALU exception codes shared by the execute-stage units (ALU, divider).
// Existing package; the divider only consumes these codes.
package alu_exc_pkg;

   typedef enum logic [1:0] {
      NO_EXCEPTION     = 2'd0,
      DIVISION_BY_ZERO = 2'd1
   } alu_exc_t;

endpackage : alu_exc_pkg

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle divide/modulus unit.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int unsigned DIV_W_MAX   = 64;
   localparam int unsigned DIV_ITER_32 = 32;
   localparam int unsigned DIV_ITER_64 = 64;

endpackage : div_pkg

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift in the next dividend bit and
// conditionally subtract the divisor. Purely combinational.
module div_iter_step #(
   parameter int unsigned W = 64
) (
   input  logic [W:0]   rem_i,
   input  logic [W-1:0] divisor_i,
   input  logic         dvd_bit_i,
   output logic [W:0]   rem_o,
   output logic         q_bit_o
);

   localparam int unsigned RW = W + 1;

   logic [W:0] shifted_s;
   logic [W:0] dsr_ext_s;

   // Shift/compare/subtract for a single quotient bit.
   always_comb begin
      shifted_s = RW'({rem_i, dvd_bit_i});
      dsr_ext_s = {1'b0, divisor_i};
      if (shifted_s >= dsr_ext_s) begin
         rem_o   = shifted_s - dsr_ext_s;
         q_bit_o = 1'b1;
      end else begin
         rem_o   = shifted_s;
         q_bit_o = 1'b0;
      end
   end

endmodule : div_iter_step

// File: rtl/div_mod_unit.sv
// Multi-cycle unsigned divide/modulus unit (one restoring iteration per cycle,
// 32- or 64-bit mode) that stalls the pipeline via ready and pulses done.
module div_mod_unit
   import div_pkg::*;
   import alu_exc_pkg::*;
#(
   parameter int unsigned W_MAX = DIV_W_MAX
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             is32Bit,
   input  logic             isMod,
   input  logic [W_MAX-1:0] dividend,
   input  logic [W_MAX-1:0] divisor,
   input  logic             flush,
   output logic             ready,
   output logic             done,
   output logic [W_MAX-1:0] result,
   output alu_exc_t         divExc
);

   localparam int unsigned HW    = W_MAX / 2;
   localparam int unsigned CNT_W = $clog2(W_MAX);

   div_state_t       state_q, state_d, state_n;
   logic [W_MAX-1:0] dvd_q, dvd_d;
   logic [W_MAX-1:0] dsr_q, dsr_d;
   logic [W_MAX-1:0] quo_q, quo_d;
   logic [W_MAX:0]   rem_q, rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             is32_q, is32_d;
   logic             ismod_q, ismod_d;
   logic [W_MAX-1:0] result_q, result_d, result_n;
   alu_exc_t         exc_q, exc_d, exc_n;
   logic             ready_q, ready_d;
   logic             done_q, done_d;

   logic [W_MAX-1:0] dvd_mask_s;
   logic [W_MAX-1:0] dsr_mask_s;
   logic [W_MAX:0]   rem_step_s;
   logic             q_bit_s;
   logic [W_MAX-1:0] quo_next_s;
   logic [W_MAX-1:0] res_sel_s;

   div_iter_step #(
      .W (W_MAX)
   ) u_step (
      .rem_i     (rem_q),
      .divisor_i (dsr_q),
      .dvd_bit_i (dvd_q[cnt_q]),
      .rem_o     (rem_step_s),
      .q_bit_o   (q_bit_s)
   );

   // Operand masking, quotient bit insertion and final result selection.
   always_comb begin
      dvd_mask_s = is32Bit ? {{HW{1'b0}}, dividend[HW-1:0]} : dividend;
      dsr_mask_s = is32Bit ? {{HW{1'b0}}, divisor[HW-1:0]}  : divisor;
      quo_next_s = quo_q;
      quo_next_s[cnt_q] = q_bit_s;
      res_sel_s  = ismod_q ? rem_step_s[W_MAX-1:0] : quo_next_s;
      if (is32_q) begin
         res_sel_s = {{HW{1'b0}}, res_sel_s[HW-1:0]};
      end else begin
         res_sel_s = res_sel_s;
      end
   end

   // FSM next state and datapath next values; flush overrides the FSM.
   always_comb begin
      state_n  = state_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      quo_d    = quo_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      is32_d   = is32_q;
      ismod_d  = ismod_q;
      result_n = result_q;
      exc_n    = exc_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dvd_mask_s;
               dsr_d   = dsr_mask_s;
               quo_d   = {W_MAX{1'b0}};
               rem_d   = {(W_MAX + 1){1'b0}};
               is32_d  = is32Bit;
               ismod_d = isMod;
               cnt_d   = is32Bit ? CNT_W'(DIV_ITER_32 - 1) : CNT_W'(DIV_ITER_64 - 1);
               if (dsr_mask_s == {W_MAX{1'b0}}) begin
                  // eBPF semantics: quotient 0, remainder is the dividend
                  state_n  = DONE;
                  result_n = isMod ? dvd_mask_s : {W_MAX{1'b0}};
                  exc_n    = DIVISION_BY_ZERO;
               end else begin
                  state_n  = CALC;
               end
            end else begin
               state_n = IDLE;
            end
         end
         CALC: begin
            rem_d = rem_step_s;
            quo_d = quo_next_s;
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_n  = DONE;
               result_n = res_sel_s;
               exc_n    = NO_EXCEPTION;
            end else begin
               state_n  = CALC;
               cnt_d    = cnt_q - CNT_W'(1);
            end
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
         exc_d    = exc_q;
      end else begin
         state_d  = state_n;
         result_d = result_n;
         exc_d    = exc_n;
      end
      ready_d = (state_d == IDLE);
      done_d  = (state_d == DONE);
   end

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         dvd_q    <= {W_MAX{1'b0}};
         dsr_q    <= {W_MAX{1'b0}};
         quo_q    <= {W_MAX{1'b0}};
         rem_q    <= {(W_MAX + 1){1'b0}};
         cnt_q    <= {CNT_W{1'b0}};
         is32_q   <= 1'b0;
         ismod_q  <= 1'b0;
         result_q <= {W_MAX{1'b0}};
         exc_q    <= NO_EXCEPTION;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         quo_q    <= quo_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         is32_q   <= is32_d;
         ismod_q  <= ismod_d;
         result_q <= result_d;
         exc_q    <= exc_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
      end
   end

   assign ready  = ready_q;
   assign done   = done_q;
   assign result = result_q;
   assign divExc = exc_q;

endmodule : div_mod_unit
